dac_wave_gen: RTL and testbench

Sample-rate waveform generator that feeds the I2C DAC write port (wr_req / wr_data / ready) of the `dac` block. It produces periodic sawtooth, triangle, square or (optionally) sine codes from an 8-bit phase accumulator and clamps them to a programmable code window. It releases one sample every TICK_DIV clocks and holds each request until the DAC reports ready. It reports dropped samples when the DAC cannot keep up.

---
 rtl/dac_wave_gen.sv | 134 +++++++++++++
 tb/tb_dac_wave_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen.sv
// Sample-rate sawtooth/triangle/square/sine waveform generator feeding the DAC write port.
// Define WAVE_SINE_EN to build the quarter-wave sine LUT for mode 11; otherwise mode 11 outputs DC = step.
module dac_wave_gen #(
  parameter int          TICK_DIV = 1_000_000,
  parameter logic [7:0]  DATA_MIN = 8'h00,
  parameter logic [7:0]  DATA_MAX = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [7:0]  step,
  input  logic        ready,
  input  logic        clr_ovf,
  output logic        wr_req,
  output logic [7:0]  wr_data,
  output logic        overrun,
  output logic [15:0] sample_cnt
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, REQ} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [7:0]    phase;
  logic [7:0]    next_phase;
  logic [7:0]    raw;
  logic [7:0]    sample;
  logic          tick;

`ifdef WAVE_SINE_EN
  localparam logic [6:0] SINE_LUT [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  // Odd quadrants read the table mirrored; the lower half-wave is reflected around mid-scale.
  function automatic logic [7:0] sine_code(input logic [7:0] p);
    logic [6:0] v;
    v = p[6] ? SINE_LUT[6'd63 - p[5:0]] : SINE_LUT[p[5:0]];
    return p[7] ? (8'd127 - {1'b0, v}) : (8'd128 + {1'b0, v});
  endfunction
`endif

  // Written with inclusive compares so a full-scale window never yields a constant compare.
  function automatic logic [7:0] clamp(input logic [7:0] v);
    if (v <= DATA_MIN)
      return DATA_MIN;
    else if (v >= DATA_MAX)
      return DATA_MAX;
    else
      return v;
  endfunction

  assign tick = enable && (count == LAST);

  always_comb begin
    next_phase = phase + step;
    raw        = next_phase;
    case (mode)
      2'b00:   raw = next_phase;
      2'b01:   raw = next_phase[7] ? ~{next_phase[6:0], 1'b0} : {next_phase[6:0], 1'b0};
`ifdef WAVE_SINE_EN
      2'b11:   raw = sine_code(next_phase);
`else
      2'b11:   raw = step;
`endif
      default: raw = next_phase;
    endcase
    if (mode == 2'b10)
      sample = next_phase[7] ? DATA_MAX : DATA_MIN;
    else
      sample = clamp(raw);
  end

  // A tick seen outside IDLE drops that sample and leaves the phase untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      phase      <= 8'h00;
      wr_req     <= 1'b0;
      wr_data    <= DATA_MIN;
      overrun    <= 1'b0;
      sample_cnt <= 16'h0000;
    end else begin
      if (!enable) begin
        count <= '0;
        phase <= 8'h00;
      end else if (tick) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end

      if (tick && (state != IDLE))
        overrun <= 1'b1;
      else if (clr_ovf)
        overrun <= 1'b0;

      wr_req <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            phase   <= next_phase;
            wr_data <= sample;
            state   <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (ready) begin
            wr_req <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          sample_cnt <= sample_cnt + 16'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen: a full-scale instance and a clamped (70..E0) instance share stimulus.
// Sine expectations are used when WAVE_SINE_EN is defined, DC expectations otherwise.
module tb_dac_wave_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  step = 8'h00;
  logic        ready = 1'b0;
  logic        clr_ovf = 1'b0;

  logic        wr_req, c_wr_req;
  logic [7:0]  wr_data, c_wr_data;
  logic        overrun, c_overrun;
  logic [15:0] sample_cnt, c_sample_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int prev_cyc = 0;
  int rel_cyc = 0;
  int n_strobes = 0;
  logic [15:0] exp_cnt = 16'h0000;
  logic [7:0]  e1, e2;

  dac_wave_gen #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .step(step),
    .ready(ready), .clr_ovf(clr_ovf), .wr_req(wr_req), .wr_data(wr_data),
    .overrun(overrun), .sample_cnt(sample_cnt)
  );

  dac_wave_gen #(.TICK_DIV(4), .DATA_MIN(8'h70), .DATA_MAX(8'hE0)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .step(step),
    .ready(ready), .clr_ovf(clr_ovf), .wr_req(c_wr_req), .wr_data(c_wr_data),
    .overrun(c_overrun), .sample_cnt(c_sample_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for the next strobe and checks both instances' data and the sample count.
  task automatic expect_sample(input string tag, input logic [7:0] x1, input logic [7:0] x2);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (wr_req !== 1'b1 && waited < 16);
    if (wr_req !== 1'b1) begin
      check({tag, "_timeout"}, {15'd0, wr_req}, 16'd1);
    end else begin
      strobe_cyc = cyc;
      check({tag, "_data"}, wr_data, x1);
      check({tag, "_cdata"}, c_wr_data, x2);
      check({tag, "_creq"}, {15'd0, c_wr_req}, 16'd1);
      check({tag, "_cnt"}, sample_cnt, exp_cnt);
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic idle_cycles(input int n, output int strobes);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wr_req === 1'b1) strobes++;
    end
  endtask

  // Stop after the current strobe, clear phase, and restart with a new waveform.
  task automatic restart(input logic [1:0] m, input logic [7:0] s);
    enable = 1'b0;
    mode   = m;
    step   = s;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
  endtask

  function automatic logic [7:0] clamp_c(input logic [7:0] v);
    if (v < 8'h70) return 8'h70;
    if (v > 8'hE0) return 8'hE0;
    return v;
  endfunction

  initial begin
    #1 rst = 1'b0;
    #1;
    check("rst_req", {15'd0, wr_req}, 16'd0);
    check("rst_data", wr_data, 16'h00);
    check("rst_cdata", c_wr_data, 16'h70);
    check("rst_ovf", {15'd0, overrun}, 16'd0);
    check("rst_cnt", sample_cnt, 16'd0);

    $display("[TB] saw step 10");
    mode = 2'b00; step = 8'h10; ready = 1'b1; enable = 1'b1;
    @(negedge clk) rst = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      e1 = 8'(i * 16);
      expect_sample($sformatf("saw%0d", i), e1, clamp_c(e1));
      if (i > 1) check($sformatf("saw%0d_gap", i), 16'(strobe_cyc - prev_cyc), 16'd4);
      prev_cyc = strobe_cyc;
      @(negedge clk);
      check($sformatf("saw%0d_pulse", i), {15'd0, wr_req}, 16'd0);
    end

    $display("[TB] triangle step 40");
    restart(2'b01, 8'h40);
    expect_sample("tri1", 8'h80, 8'h80);
    expect_sample("tri2", 8'hFF, 8'hE0);
    expect_sample("tri3", 8'h7F, 8'h7F);
    expect_sample("tri4", 8'h00, 8'h70);
    expect_sample("tri5", 8'h80, 8'h80);

    $display("[TB] square step 80");
    restart(2'b10, 8'h80);
    expect_sample("sq1", 8'hFF, 8'hE0);
    expect_sample("sq2", 8'h00, 8'h70);
    expect_sample("sq3", 8'hFF, 8'hE0);
    expect_sample("sq4", 8'h00, 8'h70);

    $display("[TB] saw step 40 clamped");
    restart(2'b00, 8'h40);
    expect_sample("saw40_1", 8'h40, 8'h70);
    expect_sample("saw40_2", 8'h80, 8'h80);
    expect_sample("saw40_3", 8'hC0, 8'hC0);
    expect_sample("saw40_4", 8'h00, 8'h70);

`ifdef WAVE_SINE_EN
    $display("[TB] sine step 40");
    restart(2'b11, 8'h40);
    expect_sample("sin1", 8'hFF, 8'hE0);
    expect_sample("sin2", 8'h7D, 8'h7D);
    expect_sample("sin3", 8'h00, 8'h70);
    expect_sample("sin4", 8'h82, 8'h82);
`else
    $display("[TB] DC step 55");
    restart(2'b11, 8'h55);
    expect_sample("dc1", 8'h55, 8'h70);
    expect_sample("dc2", 8'h55, 8'h70);
    expect_sample("dc3", 8'h55, 8'h70);
`endif

    $display("[TB] overrun with ready held low");
    ready = 1'b0;
    restart(2'b00, 8'h10);
    idle_cycles(16, n_strobes);
    check("ovf_nostrobe", 16'(n_strobes), 16'd0);
    check("ovf_set", {15'd0, overrun}, 16'd1);
    check("ovf_held_data", wr_data, 16'h10);
    ready = 1'b1;
    expect_sample("ovf_first", 8'h10, 8'h70);
    enable = 1'b0;
    idle_cycles(6, n_strobes);
    check("ovf_one_strobe", 16'(n_strobes), 16'd0);
    check("ovf_sticky", {15'd0, overrun}, 16'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_clr", {15'd0, overrun}, 16'd0);

    $display("[TB] reset while waiting for ready");
    ready = 1'b0;
    restart(2'b00, 8'h10);
    idle_cycles(6, n_strobes);
    check("mid_pending_data", wr_data, 16'h10);
    rst = 1'b0;
    #1;
    check("mid_req", {15'd0, wr_req}, 16'd0);
    check("mid_data", wr_data, 16'h00);
    check("mid_cdata", c_wr_data, 16'h70);
    check("mid_cnt", sample_cnt, 16'd0);
    exp_cnt = 16'h0000;
    ready = 1'b1;
    @(negedge clk);
    rel_cyc = cyc;
    rst = 1'b1;
    expect_sample("post_rst", 8'h10, 8'h70);
    check("post_rst_gap", {15'd0, (strobe_cyc - rel_cyc) >= 5}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
